// File: rtl/load_store_unit_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : load_store_unit_pkg
// Description : Shared definitions for the load/store unit: access-size
//               encodings, FSM state enumeration and default memory depth.
// Revision    : 1.0 - initial release
// ============================================================================
package load_store_unit_pkg;

  // Default depth of the attached data memory, in 32-bit words.
  localparam int DEFAULT_MEM_WORDS = 32;

  // req_size encodings.
  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_WR   = 3'd3,
    ST_RESP = 3'd4
  } lsu_state_e;

  // Returns 1 when an access of the given size is misaligned or illegal.
  function automatic logic size_align_err(input logic [1:0] size,
                                          input logic [1:0] offset);
    logic err;
    err = 1'b0;
    case (size)
      SZ_HALF: err = offset[0];
      SZ_WORD: err = (offset != 2'b00);
      SZ_BYTE: err = 1'b0;
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : lsu_lane_align
// Description : Combinational little-endian lane handling for the LSU.
//               Extracts and sign/zero-extends the addressed byte/half of a
//               memory word for loads, and merges store data into the
//               addressed lane of a memory word for read-modify-write.
// Revision    : 1.0 - initial release
// Ports       : rdata_i      - word read from memory
//               wdata_i      - right-aligned store data
//               size_i       - access size encoding
//               offset_i     - byte offset within the word (addr[1:0])
//               unsigned_i   - zero-extend loads when 1
//               load_data_o  - extracted and extended load result
//               merge_data_o - rdata_i with the addressed lane replaced
// ============================================================================
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  offset_i,
  input  logic        unsigned_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merge_data_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [4:0]  bit_shift;

  always_comb begin
    bit_shift    = {offset_i, 3'b000};
    byte_lane    = rdata_i[bit_shift +: 8];
    half_lane    = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    load_data_o  = rdata_i;
    merge_data_o = rdata_i;

    case (size_i)
      SZ_BYTE: begin
        load_data_o = {{24{~unsigned_i & byte_lane[7]}}, byte_lane};
        merge_data_o[bit_shift +: 8] = wdata_i[7:0];
      end
      SZ_HALF: begin
        load_data_o = {{16{~unsigned_i & half_lane[15]}}, half_lane};
        if (offset_i[1]) begin
          merge_data_o[31:16] = wdata_i[15:0];
        end else begin
          merge_data_o[15:0] = wdata_i[15:0];
        end
      end
      default: begin
        load_data_o  = rdata_i;
        merge_data_o = wdata_i;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Single-outstanding load/store unit in front of a word-wide
//               synchronous data memory. Supports byte, half and word
//               accesses; sub-word stores are done as read-modify-write.
// Revision    : 1.0 - initial release
// Ports       : clk, reset          - clock, synchronous active-high reset
//               req_valid/req_ready - request handshake
//               req_write, req_size, req_unsigned, req_addr, req_wdata
//                                   - request fields (latched on accept)
//               resp_valid/resp_rdata/resp_err
//                                   - one-cycle completion pulse
//               mem_read/mem_write/mem_addr/mem_wdata/mem_rdata
//                                   - data memory port (word indexed)
// ============================================================================
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int MEM_WORDS = DEFAULT_MEM_WORDS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  state_q;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;
  logic        mem_read_q;
  logic        mem_write_q;
  logic [31:0] mem_addr_q;
  // Doubles as the write buffer: holds req_wdata from acceptance and is
  // overwritten with the merged word in CAP for sub-word stores.
  logic [31:0] mem_wdata_q;

  // Latched request fields.
  logic        op_write_q;
  logic [1:0]  op_size_q;
  logic        op_unsigned_q;
  logic [1:0]  op_offset_q;

  logic        req_err;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  always_comb begin
    req_err = size_align_err(req_size, req_addr[1:0]) |
              ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));
  end

  lsu_lane_align u_lane_align (
    .rdata_i      (mem_rdata),
    .wdata_i      (mem_wdata_q),
    .size_i       (op_size_q),
    .offset_i     (op_offset_q),
    .unsigned_i   (op_unsigned_q),
    .load_data_o  (load_data),
    .merge_data_o (merge_data)
  );

  // Outputs are registered and updated together with the state transition,
  // so every strobe lines up exactly with the state that owns it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      req_ready_q   <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_err_q    <= 1'b0;
      resp_rdata_q  <= 32'd0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_addr_q    <= 32'd0;
      mem_wdata_q   <= 32'd0;
      op_write_q    <= 1'b0;
      op_size_q     <= SZ_BYTE;
      op_unsigned_q <= 1'b0;
      op_offset_q   <= 2'b00;
    end else begin
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      resp_valid_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            req_ready_q   <= 1'b0;
            op_write_q    <= req_write;
            op_size_q     <= req_size;
            op_unsigned_q <= req_unsigned;
            op_offset_q   <= req_addr[1:0];
            if (req_err) begin
              // Rejected: straight to the response, memory untouched.
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= 32'd0;
            end else begin
              mem_addr_q  <= {2'b00, req_addr[31:2]};
              mem_wdata_q <= req_wdata;
              if (req_write && (req_size == SZ_WORD)) begin
                state_q     <= ST_WR;
                mem_write_q <= 1'b1;
              end else begin
                state_q    <= ST_RD;
                mem_read_q <= 1'b1;
              end
            end
          end
        end

        // Memory samples mem_read on this edge; data is valid in CAP.
        ST_RD: begin
          state_q <= ST_CAP;
        end

        ST_CAP: begin
          if (op_write_q) begin
            state_q     <= ST_WR;
            mem_wdata_q <= merge_data;
            mem_write_q <= 1'b1;
          end else begin
            state_q      <= ST_RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= load_data;
          end
        end

        ST_WR: begin
          state_q      <= ST_RESP;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= 32'd0;
        end

        ST_RESP: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
        end

        default: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit with a word memory
//               model and a byte-lane reference model of the memory contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  localparam int MEM_WORDS = 32;
  localparam int AW = $clog2(MEM_WORDS);

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  // Synchronous data memory; mem_init loads word i = i.
  logic [31:0] mem [MEM_WORDS];
  logic        mem_init = 1'b1;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= 32'(i);
    end else if (mem_write && mem_addr < MEM_WORDS) begin
      mem[mem_addr[AW-1:0]] <= mem_wdata;
    end
    if (mem_read) mem_rdata <= (mem_addr < MEM_WORDS) ? mem[mem_addr[AW-1:0]] : 32'hDEAD_BEEF;
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [MEM_WORDS];

  function automatic logic ref_is_err(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b11) return 1'b1;
    if (sz == 2'b01 && (a % 2) != 0) return 1'b1;
    if (sz == 2'b10 && (a % 4) != 0) return 1'b1;
    return (a / 4) >= MEM_WORDS;
  endfunction

  // Performs the access on ref_mem and returns the expected resp_rdata.
  function automatic logic [31:0] ref_apply(input logic w, input logic [1:0] sz,
                                            input logic uns, input logic [31:0] a,
                                            input logic [31:0] wd);
    int idx, sh, nb;
    logic [31:0] mask, v;
    if (ref_is_err(sz, a)) return 32'd0;
    idx  = int'(a / 4);
    sh   = int'(a % 4) * 8;
    nb   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
    if (w) begin
      ref_mem[idx] = (ref_mem[idx] & ~(mask << sh)) | ((wd & mask) << sh);
      return 32'd0;
    end
    v = (ref_mem[idx] >> sh) & mask;
    if (!uns && v[8 * nb - 1]) v = v | ~mask;
    return v;
  endfunction

  function automatic int ref_latency(input logic w, input logic [1:0] sz, input logic [31:0] a);
    if (ref_is_err(sz, a)) return 1;
    if (w && sz == 2'b10) return 2;
    return w ? 4 : 3;
  endfunction

  // ---------------- transaction driver (no checking) ----------------
  int          obs_lat, obs_reads, obs_writes, obs_overlap, obs_extra;
  logic [31:0] obs_rdata;
  logic        obs_err;

  task automatic do_req(input logic w, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd);
    obs_lat = 99; obs_reads = 0; obs_writes = 0; obs_overlap = 0; obs_extra = 0;
    obs_rdata = 32'hXXXX_XXXX; obs_err = 1'bx;
    @(negedge clk);
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    if (!req_ready) return;
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    // Scramble inputs after acceptance; the operation must be unaffected.
    req_valid = 1'b0; req_write = ~w; req_size = 2'($urandom); req_unsigned = ~uns;
    req_addr = $urandom; req_wdata = $urandom;
    for (int k = 1; k <= 20; k++) begin
      if (mem_read) obs_reads++;
      if (mem_write) obs_writes++;
      if (mem_read && mem_write) obs_overlap++;
      if (resp_valid) begin
        obs_lat = k; obs_rdata = resp_rdata; obs_err = resp_err;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    obs_extra = int'(resp_valid) + int'(mem_read) + int'(mem_write);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; mem_init = 1'b1;
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = 32'(i);
    repeat (3) @(negedge clk);
    n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", req_ready); end
    n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    n_tests++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_resp_err: got %b want 0", resp_err); end
    n_tests++; if (resp_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_resp_rdata: got %h want 0", resp_rdata); end
    n_tests++; if ({mem_read, mem_write} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes: got %b want 00", {mem_read, mem_write}); end
    n_tests++; if (mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_mem_bus: got addr %h wdata %h want 0", mem_addr, mem_wdata); end
    reset = 1'b0; mem_init = 1'b0;
    @(negedge clk);
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_word_load();
    logic [31:0] exp;
    exp = ref_apply(1'b0, 2'b10, 1'b0, 32'h14, 32'd0);
    do_req(1'b0, 2'b10, 1'b0, 32'h14, 32'h1234_5678);
    n_tests++; if (obs_rdata !== 32'h5 || exp !== 32'h5) begin n_fail++; $display("FAIL word_load_data: got %h want %h", obs_rdata, 32'h5); end
    n_tests++; if (obs_err !== 1'b0) begin n_fail++; $display("FAIL word_load_err: got %b want 0", obs_err); end
    n_tests++; if (obs_lat != 3) begin n_fail++; $display("FAIL word_load_latency: got %0d want 3", obs_lat); end
    n_tests++; if (obs_reads != 1 || obs_writes != 0) begin n_fail++; $display("FAIL word_load_strobes: got rd %0d wr %0d want 1/0", obs_reads, obs_writes); end
  endtask

  task automatic test_byte_store_load();
    void'(ref_apply(1'b1, 2'b00, 1'b0, 32'h0D, 32'h0000_0080));
    do_req(1'b1, 2'b00, 1'b0, 32'h0D, 32'h0000_0080);
    n_tests++; if (obs_lat != 4 || obs_err !== 1'b0 || obs_rdata !== 32'd0) begin n_fail++; $display("FAIL byte_store_resp: got lat %0d err %b data %h want 4/0/0", obs_lat, obs_err, obs_rdata); end
    n_tests++; if (obs_reads != 1 || obs_writes != 1) begin n_fail++; $display("FAIL byte_store_strobes: got rd %0d wr %0d want 1/1", obs_reads, obs_writes); end
    n_tests++; if (mem[3] !== 32'h0000_8003) begin n_fail++; $display("FAIL byte_store_mem3: got %h want 00008003", mem[3]); end
    do_req(1'b0, 2'b00, 1'b0, 32'h0D, 32'd0);
    n_tests++; if (obs_rdata !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL byte_load_signed: got %h want ffffff80", obs_rdata); end
    do_req(1'b0, 2'b00, 1'b1, 32'h0D, 32'd0);
    n_tests++; if (obs_rdata !== 32'h0000_0080) begin n_fail++; $display("FAIL byte_load_unsigned: got %h want 00000080", obs_rdata); end
  endtask

  task automatic test_half_store_load();
    void'(ref_apply(1'b1, 2'b01, 1'b1, 32'h1A, 32'h1234_BEEF));
    do_req(1'b1, 2'b01, 1'b1, 32'h1A, 32'h1234_BEEF);
    n_tests++; if (obs_lat != 4) begin n_fail++; $display("FAIL half_store_latency: got %0d want 4", obs_lat); end
    n_tests++; if (mem[6] !== 32'hBEEF_0006) begin n_fail++; $display("FAIL half_store_mem6: got %h want beef0006", mem[6]); end
    do_req(1'b0, 2'b01, 1'b0, 32'h1A, 32'd0);
    n_tests++; if (obs_rdata !== 32'hFFFF_BEEF || obs_lat != 3) begin n_fail++; $display("FAIL half_load_signed: got %h lat %0d want ffffbeef lat 3", obs_rdata, obs_lat); end
  endtask

  task automatic test_errors();
    logic [1:0]  sz_t [4] = '{2'b10, 2'b01, 2'b11, 2'b10};
    logic [31:0] ad_t [4] = '{32'h06, 32'h03, 32'h04, 32'h80};
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, sz_t[i], 1'b0, ad_t[i], 32'hFFFF_FFFF);
      n_tests++;
      if (obs_err !== 1'b1 || obs_lat != 1 || obs_rdata !== 32'd0 || obs_reads != 0 || obs_writes != 0) begin
        n_fail++;
        $display("FAIL error_case%0d: got err %b lat %0d data %h rd %0d wr %0d want 1/1/0/0/0",
                 i, obs_err, obs_lat, obs_rdata, obs_reads, obs_writes);
      end
    end
    // Error store must not write either.
    do_req(1'b1, 2'b10, 1'b0, 32'h7E, 32'hFFFF_FFFF);
    n_tests++; if (obs_err !== 1'b1 || obs_writes != 0 || mem[31] !== ref_mem[31]) begin n_fail++; $display("FAIL error_store: got err %b wr %0d mem31 %h want 1/0/%h", obs_err, obs_writes, mem[31], ref_mem[31]); end
  endtask

  task automatic test_reset_mid_op();
    int bad_strobe;
    bad_strobe = 0;
    @(negedge clk);
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
    req_addr = 32'h08; req_wdata = 32'h0000_CAFE;
    @(posedge clk);            // accept -> RD
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);            // -> CAP
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (mem_write || resp_valid || req_ready) bad_strobe++;
    end
    reset = 1'b0;
    @(negedge clk);
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_ready: got %b want 1", req_ready); end
    repeat (3) begin
      if (mem_write || resp_valid) bad_strobe++;
      @(negedge clk);
    end
    n_tests++; if (bad_strobe != 0) begin n_fail++; $display("FAIL midreset_strobes: got %0d stray cycles want 0", bad_strobe); end
    n_tests++; if (mem[2] !== 32'd2) begin n_fail++; $display("FAIL midreset_mem2: got %h want 00000002", mem[2]); end
  endtask

  task automatic test_random(input int n);
    logic        w, uns;
    logic [1:0]  sz;
    logic [31:0] a, wd, exp_d;
    logic        exp_e;
    int          exp_l, exp_rd, exp_wr;
    for (int t = 0; t < n; t++) begin
      w   = 1'($urandom);
      uns = 1'($urandom);
      sz  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a   = 32'($urandom_range(0, MEM_WORDS * 4 + 11));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b10) a = a & ~32'd3;
        if (sz == 2'b01) a = a & ~32'd1;
      end
      wd     = $urandom;
      exp_e  = ref_is_err(sz, a);
      exp_l  = ref_latency(w, sz, a);
      exp_rd = (exp_e || (w && sz == 2'b10)) ? 0 : 1;
      exp_wr = (exp_e || !w) ? 0 : 1;
      exp_d  = ref_apply(w, sz, uns, a, wd);
      do_req(w, sz, uns, a, wd);
      n_tests++;
      if (obs_rdata !== exp_d || obs_err !== exp_e || obs_lat != exp_l ||
          obs_reads != exp_rd || obs_writes != exp_wr || obs_overlap != 0 || obs_extra != 0) begin
        n_fail++;
        $display("FAIL random%0d w%b sz%b a%h: got data %h err %b lat %0d rd %0d wr %0d ov %0d ex %0d want %h/%b/%0d/%0d/%0d/0/0",
                 t, w, sz, a, obs_rdata, obs_err, obs_lat, obs_reads, obs_writes, obs_overlap, obs_extra,
                 exp_d, exp_e, exp_l, exp_rd, exp_wr);
      end
    end
    for (int i = 0; i < MEM_WORDS; i++) begin
      n_tests++;
      if (mem[i] !== ref_mem[i]) begin n_fail++; $display("FAIL mem_final[%0d]: got %h want %h", i, mem[i], ref_mem[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_store_load();
    test_half_store_load();
    test_errors();
    test_reset_mid_op();
    test_random(80);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 32, number of 32-bit words in attached data memory.
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports req_valid  input  1  request present; req_ready  output  1  unit can accept.
REQ-005 SHALL have ports req_write  input  1  store=1/load=0; req_size  input  2  00 byte, 01 half, 10 word, 11 illegal; req_unsigned  input  1  zero-extend loads.
REQ-006 SHALL have ports req_addr  input  32  byte address; req_wdata  input  32  store data, right-aligned.
REQ-007 SHALL have ports resp_valid  output  1  completion pulse; resp_rdata  output  32  load result; resp_err  output  1  request rejected.
REQ-008 SHALL have ports mem_read  output  1; mem_write  output  1; mem_addr  output  32  word index; mem_wdata  output  32; mem_rdata  input  32  data registered by memory on edge where mem_read sampled high.

Function
REQ-009 SHALL accept a request on a rising edge where req_valid and req_ready are both 1; req_ready SHALL be 1 only in IDLE.
REQ-010 SHALL implement states IDLE, RD, CAP, WR, RESP.
REQ-011 On acceptance: error request -> RESP; word store -> WR; load or sub-word store -> RD.
REQ-012 Error SHALL be: req_size=11; half with addr[0]=1; word with addr[1:0]!=0; addr[31:2] >= MEM_WORDS. Errors SHALL issue no mem_read/mem_write.
REQ-013 RD: mem_read=1, mem_addr=addr[31:2] zero-extended; next CAP.
REQ-014 CAP: mem_rdata valid; load -> extract lane, extend, store in result register, next RESP; sub-word store -> merge lane into read word, store in write buffer, next WR.
REQ-015 WR: mem_write=1 for exactly one cycle, mem_addr=word index, mem_wdata=write buffer (req_wdata for word store); next RESP.
REQ-016 RESP: resp_valid=1 for exactly one cycle, resp_err per REQ-012; next IDLE. No backpressure on response.
REQ-017 Little-endian lanes: byte k=addr[1:0] at bits [8k+7:8k]; half at [31:16] if addr[1]=1 else [15:0].
REQ-018 Signed loads SHALL replicate lane MSB; unsigned loads zero-fill; stores ignore req_unsigned.
REQ-019 Sub-word stores SHALL leave non-addressed bytes unchanged (read-modify-write).
REQ-020 resp_valid latency after acceptance edge: error 1, word store 2, load 3, sub-word store 4 cycles.
REQ-021 resp_rdata SHALL be 0 for stores and errors, load result otherwise; held until next response.
REQ-022 mem_read and mem_write SHALL never be high in the same cycle; both 0 outside RD/WR.
REQ-023 Request fields SHALL be latched at acceptance; later input changes SHALL not affect the operation.

Reset
REQ-024 While reset=1: state IDLE, req_ready=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
REQ-025 Reset mid-operation SHALL abort without any write or response; req_ready=1 in first cycle after reset deasserts.

Structure
REQ-026 Shared package SHALL hold size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), state enum, and default MEM_WORDS.
REQ-027 Lane extract/extend and lane merge SHALL be one combinational sub-module lsu_lane_align; FSM and registers in load_store_unit.

Verification (memory reset to word i = i)
REQ-028 Word load addr 0x14 -> resp_valid 3 cycles after accept, resp_rdata=0x00000005, resp_err=0, one mem_read, no mem_write.
REQ-029 Byte store 0x80 to 0x0D, then signed byte load 0x0D -> 0xFFFFFF80; unsigned -> 0x00000080; word 3 = 0x00008003.
REQ-030 Half store 0xBEEF to 0x1A -> word 6 = 0xBEEF0006, resp_valid 4 cycles after accept; signed half load 0x1A -> 0xFFFFBEEF.
REQ-031 Word load 0x06, half load 0x03, size=11, word load 0x80 -> each resp_err=1 one cycle after accept, no memory strobes, resp_rdata=0.
REQ-032 Reset asserted during CAP of half store to 0x08 -> no mem_write, no resp_valid, word 2 unchanged, req_ready=1 one cycle after reset release.
